// File: rtl/systolic_mm_engine.sv
// NxN systolic matrix-multiply engine: streams in A rows and B columns, skews them
// through a PE grid, then drains C row by row over a backpressured stream.
module systolic_mm_engine #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned ACCW = 2 * DW + $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode_signed,
    output logic                   busy,
    output logic                   done,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*DW-1:0]        in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   out_row,
    output logic [N*ACCW-1:0]      out_data
);
    localparam int unsigned RW = $clog2(N);
    localparam int unsigned CW = $clog2(3 * N);

    typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   row_q;
    logic            mode_q;
    logic            busy_q, done_q, in_ready_q, out_valid_q;

    logic [DW-1:0]   a_buf_q  [N][N];
    logic [DW-1:0]   b_buf_q  [N][N];
    logic [DW-1:0]   a_pipe_q [N][N];
    logic [DW-1:0]   b_pipe_q [N][N];
    logic [ACCW-1:0] acc_q    [N][N];

    logic [DW-1:0]   a_edge [N];
    logic [DW-1:0]   b_edge [N];
    logic [DW-1:0]   a_in   [N][N];
    logic [DW-1:0]   b_in   [N][N];
    logic [ACCW-1:0] prod   [N][N];

    function automatic logic [ACCW-1:0] ext(input logic [DW-1:0] v, input logic s);
        ext = {{(ACCW-DW){s & v[DW-1]}}, v};
    endfunction

    // Diagonal skew at the array edges, then PE operand routing and products.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_edge[i] = '0;
            b_edge[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(cnt_q) == i + k) begin
                    a_edge[i] = a_buf_q[i][k];
                    b_edge[i] = b_buf_q[k][i];
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = a_edge[i];
            b_in[0][i] = b_edge[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_pipe_q[i][j-1];
                b_in[j][i] = b_pipe_q[j-1][i];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j] = ext(a_in[i][j], mode_q) * ext(b_in[i][j], mode_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_buf_q[i][j]  <= '0;
                    b_buf_q[i][j]  <= '0;
                    a_pipe_q[i][j] <= '0;
                    b_pipe_q[i][j] <= '0;
                    acc_q[i][j]    <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        mode_q     <= mode_signed;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready_q) begin
                        for (int i = 0; i < N; i++) begin
                            for (int k = 0; k < N; k++) begin
                                if (int'(cnt_q) == i)
                                    a_buf_q[i][k] <= in_data[k*DW +: DW];
                                if (int'(cnt_q) == int'(N) + i)
                                    b_buf_q[k][i] <= in_data[k*DW +: DW];
                            end
                        end
                        if (cnt_q == CW'(2 * N - 1)) begin
                            state_q    <= FEED;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            // Flush pipes too, so no operand from a prior job leaks in.
                            for (int i = 0; i < N; i++) begin
                                for (int j = 0; j < N; j++) begin
                                    a_pipe_q[i][j] <= '0;
                                    b_pipe_q[i][j] <= '0;
                                    acc_q[i][j]    <= '0;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                FEED: begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            a_pipe_q[i][j] <= a_in[i][j];
                            b_pipe_q[i][j] <= b_in[i][j];
                            acc_q[i][j]    <= acc_q[i][j] + prod[i][j];
                        end
                    end
                    if (cnt_q == CW'(3 * N - 3)) begin
                        state_q     <= DRAIN;
                        row_q       <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        // Rows shift up so the current result row is always acc_q[0].
                        for (int i = 0; i < N - 1; i++) begin
                            for (int j = 0; j < N; j++) begin
                                acc_q[i][j] <= acc_q[i+1][j];
                            end
                        end
                        if (row_q == RW'(N - 1)) begin
                            state_q     <= IDLE;
                            row_q       <= '0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_row   = row_q;

    for (genvar j = 0; j < N; j++) begin : g_out
        assign out_data[j*ACCW +: ACCW] = acc_q[0][j];
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine (N=4, DW=8): job table plus a
// reset-abort sequence, results checked against a scoreboard queue.
module tb_systolic_mm_engine;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int ACCW = 18;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              mode_signed = 1'b0;
    logic              busy, done;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*DW-1:0]   in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [1:0]        out_row;
    logic [N*ACCW-1:0] out_data;

    systolic_mm_engine #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_signed(mode_signed),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        row;
        logic [N*ACCW-1:0] data;
    } exp_t;

    typedef struct {
        int              kind;
        logic            mode;
        bit              use_exp;
        logic [ACCW-1:0] exp_v;
        bit              gaps;
        bit              stall;
        bit              abort;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   jobs_done = 0;
    bit   mon_en = 1'b0;
    bit   loading = 1'b0;
    int   am [N][N];
    int   bm [N][N];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [N*ACCW-1:0] act, input logic [N*ACCW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) done_cnt++;
            if (!loading) chk("in_ready_outside_load", {71'd0, in_ready}, '0);
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_busy",      {71'd0, busy},      '0);
        chk("rst_done",      {71'd0, done},      '0);
        chk("rst_in_ready",  {71'd0, in_ready},  '0);
        chk("rst_out_valid", {71'd0, out_valid}, '0);
        chk("rst_out_row",   {70'd0, out_row},   '0);
        chk("rst_out_data",  out_data,           '0);
    endtask

    function automatic int sx(input int v, input logic m);
        return (m && v > 127) ? v - 256 : v;
    endfunction

    task automatic build(input int kind);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                case (kind)
                    0: begin am[i][j] = (i == j) ? 1 : 0; bm[i][j] = 4 * i + j; end
                    1: begin am[i][j] = 255; bm[i][j] = 255; end
                    2: begin am[i][j] = 128; bm[i][j] = 128; end
                    3: begin am[i][j] = 128; bm[i][j] = 1; end
                    default: begin
                        am[i][j] = int'($urandom_range(0, 255));
                        bm[i][j] = int'($urandom_range(0, 255));
                    end
                endcase
            end
        end
    endtask

    task automatic run_job(input vec_t v);
        int   c0, w, got, tmo, stall_left;
        bit   first, stalled, lat_chk;
        exp_t e, held;
        build(v.kind);
        if (!v.abort) begin
            for (int r = 0; r < N; r++) begin
                e.row = 2'(r);
                for (int j = 0; j < N; j++) begin
                    int s = 0;
                    for (int k = 0; k < N; k++) s += sx(am[r][k], v.mode) * sx(bm[k][j], v.mode);
                    e.data[j*ACCW +: ACCW] = v.use_exp ? v.exp_v : ACCW'(s);
                end
                exp_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        start = 1'b1; mode_signed = v.mode; c0 = cyc; loading = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode_signed = ~v.mode;
        for (int b = 0; b < 2 * N; b++) begin
            if (v.gaps) begin
                in_valid = 1'b0;
                if (b == 3) start = 1'b1;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; start = 1'b0; end
            end
            in_valid = 1'b1;
            for (int k = 0; k < N; k++)
                in_data[k*DW +: DW] = (b < N) ? DW'(am[b][k]) : DW'(bm[k][b-N]);
            w = 0;
            do begin @(negedge clk); w++; end while (!in_ready && w < 50);
            chk("in_ready_wait", {71'd0, in_ready}, 72'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        loading = 1'b0;
        if (v.abort) begin
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            #1 chk_reset_outputs();
            @(posedge clk); #1 rst = 1'b0;
            return;
        end
        lat_chk = !v.gaps && !v.stall;
        first = 1'b1; stalled = 1'b0; stall_left = 0; got = 0; tmo = 0;
        while (got < N && tmo < 200) begin
            @(negedge clk); tmo++;
            if (out_valid && first) begin
                first = 1'b0;
                if (lat_chk) chk("latency", 72'(cyc - c0), 72'd19);
            end
            if (v.stall && out_valid && out_row == 2'd1 && !stalled) begin
                stalled = 1'b1; stall_left = 5; out_ready = 1'b0; start = 1'b1;
                held.row = out_row; held.data = out_data;
            end else if (stall_left > 0) begin
                start = 1'b0;
                chk("stall_row_hold",  {70'd0, out_row}, {70'd0, held.row});
                chk("stall_data_hold", out_data, held.data);
                chk("stall_valid_hold", {71'd0, out_valid}, 72'd1);
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", {70'd0, out_row}, '1);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_row",  {70'd0, out_row}, {70'd0, e.row});
                    chk("out_data", out_data, e.data);
                end
                got++;
            end
        end
        chk("drain_timeout", 72'(got), 72'(N));
        @(negedge clk);
        chk("done_pulse", {71'd0, done}, 72'd1);
        chk("busy_at_done", {71'd0, busy}, '0);
        @(negedge clk);
        chk("done_one_cycle", {71'd0, done}, '0);
        jobs_done++;
        chk("done_count", 72'(done_cnt), 72'(jobs_done));
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{0, 1'b0, 1'b0, 18'd0,       1'b0, 1'b0, 1'b0};
        tbl[1] = '{1, 1'b0, 1'b1, 18'h3F804,   1'b0, 1'b0, 1'b0};
        tbl[2] = '{2, 1'b1, 1'b1, 18'd65536,   1'b0, 1'b0, 1'b0};
        tbl[3] = '{3, 1'b1, 1'b1, 18'h3FE00,   1'b0, 1'b0, 1'b0};
        tbl[4] = '{4, 1'b0, 1'b0, 18'd0,       1'b1, 1'b1, 1'b0};
        tbl[5] = '{4, 1'b1, 1'b0, 18'd0,       1'b0, 1'b0, 1'b1};
        tbl[6] = '{4, 1'b1, 1'b0, 18'd0,       1'b0, 1'b0, 1'b0};
        tbl[7] = '{2, 1'b0, 1'b0, 18'd0,       1'b1, 1'b1, 1'b0};

        #2 rst = 1'b1;
        #10 chk_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;
        mon_en = 1'b1;

        for (int t = 0; t < 8; t++) run_job(tbl[t]);

        repeat (3) @(negedge clk);
        chk("idle_busy", {71'd0, busy}, '0);
        chk("queue_empty", 72'(exp_q.size()), '0);
        chk("final_done_count", 72'(done_cnt), 72'(jobs_done));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
